sd_cmd_resp_rx: RTL
===================

// Module: sd_cmd_resp_rx
// PURPOSE
//  CMD-line response receiver; sits directly downstream of the command sender in sd_host_controller.
//  Armed when the sender finishes a command. Samples the card's CMD line once per SD-clock rising strobe.
//  Captures a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response and checks start, transmission and end bits plus CRC7.
//  Hands the result to the init/command FSM as a single-cycle valid pulse with status flags.
// PARAMETERS
//  NCR_MAX   64  SD clocks allowed between arm and start bit before timeout is flagged
// PORTS
//  clk          in   1    system clock (sole clock)
//  reset        in   1    synchronous, active-high reset
//  sd_clk_rise  in   1    1-clk strobe from clock divider; marks SD-clock rising edge (sample point)
//  cmd_in       in   1    sampled CMD pin (pulled up; 1 when card not driving)
//  arm          in   1    1-clk pulse from sender on command end; starts response wait
//  resp_long    in   1    qualifies arm: 1 = 136-bit R2, 0 = 48-bit
//  crc_chk      in   1    qualifies arm: 0 = skip CRC7 compare (R3)
//  exp_index    in   6    qualifies arm: expected command index (used only with SD_RESP_INDEX_CHECK_EN)
//  abort        in   1    return to IDLE immediately; no resp_valid
//  busy         out  1    high from arm until resp_valid or abort
//  resp_valid   out  1    1-clk pulse; response done (good or bad)
//  resp_data    out  136  captured frame, right-aligned (48-bit frames in [47:0], [135:48]=0)
//  crc_err      out  1    CRC7 mismatch (valid with resp_valid)
//  frame_err    out  1    transmission bit !=0 or end bit !=1
//  timeout      out  1    no start bit within NCR_MAX SD clocks
//  idx_err      out  1    index mismatch (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; busy, resp_valid, all flags =0; resp_data=0. Reset mid-frame discards partial data.
//  Samples occur only on clk cycles with sd_clk_rise=1. No other cycle changes the shift/bit counters.
//  States:
//   - IDLE: arm -> WAIT. Latch resp_long/crc_chk/exp_index; clear flags and resp_data; nc_cnt=0; busy=1.
//     arm while busy is ignored.
//   - WAIT: per sample, cmd_in=0 -> RECV (start bit shifted in, bit_cnt=1, CRC fed). Else nc_cnt++.
//     When nc_cnt reaches NCR_MAX -> DONE with timeout=1.
//   - RECV: shift cmd_in MSB-first into resp_data, bit_cnt++. On the sample where bit_cnt reaches
//     48 (or 136) -> DONE.
//   - DONE: resp_valid=1 for exactly one clk; busy=0; -> IDLE. Flags and resp_data hold until next arm.
//  Latency: resp_valid asserts on the clk after the sample of the end bit.
//  CRC7: poly x^7+x^3+1, init 0, serial.
//   - 48-bit: covers frame bits [47:8]; compare with [7:1].
//   - 136-bit: covers [127:8] (CID/CSD payload); compare with [7:1]. Start/trans/reserved bits excluded.
//  frame_err:
//   - 48-bit: bit[46]!=0 or bit[0]!=1.
//   - 136-bit: bit[134]!=0, bits[133:128]!=6'b111111, or bit[0]!=1.
//  crc_chk=0: crc_err forced 0.
//  Counters: nc_cnt width clog2(NCR_MAX+1); bit_cnt 8 bits; neither wraps (leave state at terminal count).
//  abort (any state): -> IDLE next clk, busy=0, no resp_valid, flags cleared. abort beats arm in same cycle.
//  arm on the same cycle as DONE is ignored.
// CONFIGURATION
//  SD_RESP_INDEX_CHECK_EN defined:
//   - 48-bit frames: idx_err = (bits[45:40] != latched exp_index).
//   - R2 frames never flag idx_err.
//  Undefined: idx_err tied 0; exp_index ignored. Ports unchanged.
// TESTING
//  1. arm, resp_long=0, crc_chk=1; drive R7 frame 48'h08_0000_01AA_13 -> resp_valid 1 clk after end bit;
//     resp_data[47:0]=48'h080000_01AA13; all flags 0.
//  2. Same frame with bit[20] flipped -> crc_err=1, frame_err=0, data captured as driven.
//  3. arm, crc_chk=0; R3 48'h3F_00FF_8000_FF -> crc_err=0, frame_err=0, resp_data matches.
//  4. arm; hold cmd_in=1 -> timeout=1, resp_valid on the NCR_MAX-th sample +1 clk; resp_data=0.
//  5. arm, resp_long=1; R2 = {2'b00, 6'h3F, CID with valid internal CRC, 1'b1} -> no flags; arm again;
//     reset at bit 60 -> outputs 0 next clk, IDLE.
//  6. With SD_RESP_INDEX_CHECK_EN: exp_index=55, frame index 41 -> idx_err=1. Abort mid-RECV -> no resp_valid, busy=0.

Source files
------------

// File: rtl/sd_cmd_resp_rx.sv
// SD CMD-line response receiver: captures 48-bit or 136-bit responses and checks framing and CRC7.
// Optional build macro SD_RESP_INDEX_CHECK_EN adds a check of the command index on 48-bit responses.
module sd_cmd_resp_rx #(
  parameter int NCR_MAX = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sd_clk_rise,
  input  logic         cmd_in,
  input  logic         arm,
  input  logic         resp_long,
  input  logic         crc_chk,
  input  logic [5:0]   exp_index,
  input  logic         abort,
  output logic         busy,
  output logic         resp_valid,
  output logic [135:0] resp_data,
  output logic         crc_err,
  output logic         frame_err,
  output logic         timeout,
  output logic         idx_err
);

  // Handshake: arm is a one-cycle request, accepted only in IDLE; resp_valid is a one-cycle
  // pulse with no back-pressure, and resp_data/flags stay stable until the next accepted arm.
  localparam int NC_W = $clog2(NCR_MAX + 1);
  localparam logic [NC_W-1:0] NC_LAST = NC_W'(NCR_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RECV,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            long_q, long_d;
  logic            chk_q, chk_d;
  logic [NC_W-1:0] nc_q, nc_d;
  logic [7:0]      bit_q, bit_d;
  logic [135:0]    data_q, data_d;
  logic [6:0]      crc_q, crc_d;
  logic            crc_err_q, crc_err_d;
  logic            frame_err_q, frame_err_d;
  logic            timeout_q, timeout_d;
  logic            idx_err_q, idx_err_d;

  logic [135:0]    shifted;
  logic [7:0]      bit_inc;
  logic [7:0]      frame_len;
  logic            crc_fb;
  logic [6:0]      crc_next;
  logic            in_crc;
  logic            frame_bad;
  logic            idx_bad;

`ifdef SD_RESP_INDEX_CHECK_EN
  logic [5:0]      idx_q, idx_d;
`else
  logic            unused_exp_index;
  assign unused_exp_index = ^exp_index;
`endif

  always_comb begin
    shifted   = {data_q[134:0], cmd_in};
    bit_inc   = bit_q + 8'd1;
    frame_len = long_q ? 8'd136 : 8'd48;
    crc_fb    = crc_q[6] ^ cmd_in;
    crc_next  = {crc_q[5:3], crc_q[2] ^ crc_fb, crc_q[1:0], crc_fb};
    // bit_q is the count of bits already received, so it maps to frame position len-1-bit_q
    in_crc    = long_q ? ((bit_q >= 8'd8) && (bit_q < 8'd128)) : (bit_q < 8'd40);
    if (long_q) begin
      frame_bad = shifted[134] | (shifted[133:128] != 6'h3F) | ~shifted[0];
    end else begin
      frame_bad = shifted[46] | ~shifted[0];
    end
`ifdef SD_RESP_INDEX_CHECK_EN
    idx_bad = ~long_q && (shifted[45:40] != idx_q);
`else
    idx_bad = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    long_d      = long_q;
    chk_d       = chk_q;
    nc_d        = nc_q;
    bit_d       = bit_q;
    data_d      = data_q;
    crc_d       = crc_q;
    crc_err_d   = crc_err_q;
    frame_err_d = frame_err_q;
    timeout_d   = timeout_q;
    idx_err_d   = idx_err_q;
`ifdef SD_RESP_INDEX_CHECK_EN
    idx_d       = idx_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d     = S_WAIT;
          long_d      = resp_long;
          chk_d       = crc_chk;
          nc_d        = '0;
          bit_d       = '0;
          data_d      = '0;
          crc_d       = '0;
          crc_err_d   = 1'b0;
          frame_err_d = 1'b0;
          timeout_d   = 1'b0;
          idx_err_d   = 1'b0;
`ifdef SD_RESP_INDEX_CHECK_EN
          idx_d       = exp_index;
`endif
        end
      end
      S_WAIT: begin
        if (sd_clk_rise) begin
          if (!cmd_in) begin
            state_d = S_RECV;
            data_d  = shifted;
            bit_d   = 8'd1;
            if (in_crc) crc_d = crc_next;
          end else if (nc_q == NC_LAST) begin
            nc_d      = nc_q + 1'b1;
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end else begin
            nc_d = nc_q + 1'b1;
          end
        end
      end
      S_RECV: begin
        if (sd_clk_rise) begin
          data_d = shifted;
          bit_d  = bit_inc;
          if (in_crc) crc_d = crc_next;
          if (bit_inc == frame_len) begin
            // the CRC register is complete: the trailing CRC/end bits are never fed into it
            state_d     = S_DONE;
            crc_err_d   = chk_q && (crc_q != shifted[7:1]);
            frame_err_d = frame_bad;
            idx_err_d   = idx_bad;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d     = S_IDLE;
      crc_err_d   = 1'b0;
      frame_err_d = 1'b0;
      timeout_d   = 1'b0;
      idx_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      long_q      <= 1'b0;
      chk_q       <= 1'b0;
      nc_q        <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      crc_q       <= '0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      idx_err_q   <= 1'b0;
`ifdef SD_RESP_INDEX_CHECK_EN
      idx_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      long_q      <= long_d;
      chk_q       <= chk_d;
      nc_q        <= nc_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      crc_q       <= crc_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
      idx_err_q   <= idx_err_d;
`ifdef SD_RESP_INDEX_CHECK_EN
      idx_q       <= idx_d;
`endif
    end
  end

  assign busy       = (state_q == S_WAIT) || (state_q == S_RECV);
  assign resp_valid = (state_q == S_DONE);
  assign resp_data  = data_q;
  assign crc_err    = crc_err_q;
  assign frame_err  = frame_err_q;
  assign timeout    = timeout_q;
  assign idx_err    = idx_err_q;

endmodule
